// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding selects, load-use / multicycle stall and redirect flush control.
// Zero latency: all outputs are combinational. A stall holds PC and IF/ID and bubbles ID/EXE.
module hazard_ctrl #(
   parameter int NUM_STAGES = 3,
   parameter int LOAD_STAGE = 2,
   parameter int MC_LAT_W   = 6,
   localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                idValid,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   input  logic                useRs1,
   input  logic                useRs2,
   input  logic [4:0]          idRd,
   input  logic                idWreg,
   input  logic                idIsLoad,
   input  logic                idIsMc,
   input  logic [MC_LAT_W-1:0] idMcLat,
   input  logic                redirect,
   output logic [SEL_W-1:0]    qaSel,
   output logic [SEL_W-1:0]    qbSel,
   output logic                pcStall,
   output logic                ifidStall,
   output logic                idexBubble,
   output logic                ifidFlush,
   output logic                mcBusy
);

   // Tracker: index i holds the instruction in stage i+1 (index 0 = EXE).
   logic [NUM_STAGES-1:0] tv;
   logic [NUM_STAGES-1:0] twreg;
   logic [NUM_STAGES-1:0] tld;
   logic [4:0]            trd [NUM_STAGES];
   logic [MC_LAT_W-1:0]   mcCnt;

   logic [SEL_W:0] look_a;
   logic [SEL_W:0] look_b;
   logic           loadUse;
   logic           stall;
   logic           issue;

   // Returns {load-use hazard, forward select}; youngest matching stage wins.
   function automatic logic [SEL_W:0] lookup(input logic use_src, input logic [4:0] rs);
      logic hit;
      logic hit_ld;
      int   idx;
      hit    = 1'b0;
      hit_ld = 1'b0;
      idx    = 0;
      for (int i = NUM_STAGES; i >= 1; i--) begin
         if (tv[i-1] && twreg[i-1] && (trd[i-1] == rs)) begin
            hit    = 1'b1;
            hit_ld = tld[i-1];
            idx    = i;
         end
      end
      if (!use_src || (rs == 5'd0) || !hit)
         lookup = '0;
      else if (hit_ld && (idx < LOAD_STAGE))
         lookup = {1'b1, {SEL_W{1'b0}}};
      else
         lookup = {1'b0, SEL_W'(idx)};
   endfunction

   always_comb begin
      look_a = lookup(useRs1, rs1);
      look_b = lookup(useRs2, rs2);
   end

   assign mcBusy  = (mcCnt != '0);
   assign loadUse = look_a[SEL_W] | look_b[SEL_W];
   assign stall   = idValid & (loadUse | mcBusy);
   assign issue   = idValid & ~stall & ~redirect;

   assign qaSel      = look_a[SEL_W-1:0];
   assign qbSel      = look_b[SEL_W-1:0];
   // A redirect overrides the stall: the wrong-path ID instruction is discarded instead.
   assign pcStall    = stall & ~redirect;
   assign ifidStall  = stall & ~redirect;
   assign idexBubble = stall | redirect;
   assign ifidFlush  = redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv    <= '0;
         mcCnt <= '0;
      end else begin
         if (!mcBusy) begin
            tv[0] <= issue;
            for (int i = 1; i < NUM_STAGES; i++) tv[i] <= tv[i-1];
         end else begin
            // EXE is occupied: stage 1 holds, a bubble enters stage 2.
            tv[1] <= 1'b0;
            for (int i = 2; i < NUM_STAGES; i++) tv[i] <= tv[i-1];
         end

         if (issue && idIsMc)
            mcCnt <= (idMcLat == '0) ? '0 : idMcLat - MC_LAT_W'(1);
         else if (mcCnt != '0)
            mcCnt <= mcCnt - MC_LAT_W'(1);
      end
   end

   // Payload fields are qualified by tv, so they need no reset.
   always_ff @(posedge clk) begin
      if (!mcBusy) begin
         trd[0]   <= idRd;
         twreg[0] <= idWreg;
         tld[0]   <= idIsLoad;
         for (int i = 1; i < NUM_STAGES; i++) begin
            trd[i]   <= trd[i-1];
            twreg[i] <= twreg[i-1];
            tld[i]   <= tld[i-1];
         end
      end else begin
         for (int i = 2; i < NUM_STAGES; i++) begin
            trd[i]   <= trd[i-1];
            twreg[i] <= twreg[i-1];
            tld[i]   <= tld[i-1];
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (3/2 and 5/3 stage configs) share stimulus,
// each checked against a queue-based pipeline model through an expected-response scoreboard.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       idValid;
   logic [4:0] rs1, rs2, idRd;
   logic       useRs1, useRs2, idWreg, idIsLoad, idIsMc, redirect;
   logic [5:0] idMcLat;

   logic [1:0] qa0, qb0;
   logic       pcs0, ifs0, bub0, fl0, busy0;
   logic [2:0] qa1, qb1;
   logic       pcs1, ifs1, bub1, fl1, busy1;

   hazard_ctrl #(.NUM_STAGES(3), .LOAD_STAGE(2), .MC_LAT_W(6)) dut0 (
      .clk(clk), .rst_n(rst_n), .idValid(idValid), .rs1(rs1), .rs2(rs2),
      .useRs1(useRs1), .useRs2(useRs2), .idRd(idRd), .idWreg(idWreg),
      .idIsLoad(idIsLoad), .idIsMc(idIsMc), .idMcLat(idMcLat), .redirect(redirect),
      .qaSel(qa0), .qbSel(qb0), .pcStall(pcs0), .ifidStall(ifs0),
      .idexBubble(bub0), .ifidFlush(fl0), .mcBusy(busy0));

   hazard_ctrl #(.NUM_STAGES(5), .LOAD_STAGE(3), .MC_LAT_W(6)) dut1 (
      .clk(clk), .rst_n(rst_n), .idValid(idValid), .rs1(rs1), .rs2(rs2),
      .useRs1(useRs1), .useRs2(useRs2), .idRd(idRd), .idWreg(idWreg),
      .idIsLoad(idIsLoad), .idIsMc(idIsMc), .idMcLat(idMcLat), .redirect(redirect),
      .qaSel(qa1), .qbSel(qb1), .pcStall(pcs1), .ifidStall(ifs1),
      .idexBubble(bub1), .ifidFlush(fl1), .mcBusy(busy1));

   typedef struct packed {logic v; logic [4:0] rd; logic w; logic ld;} ent_t;
   typedef struct packed {logic [2:0] sa; logic [2:0] sb; logic pcs; logic ifs; logic bub; logic fl; logic busy;} exp_t;

   ent_t pipe0[$], pipe1[$];
   int   mc0, mc1;
   bit   iss0, iss1;
   exp_t expq0[$], expq1[$];
   exp_t me0, me1;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear(output ent_t p[$], output int mc, input int ns);
      p.delete();
      for (int i = 0; i < ns; i++) p.push_back('0);
      mc = 0;
   endfunction

   // Youngest older instruction writing rs decides the source of the operand.
   function automatic void lookup(input ent_t p[$], input bit u, input logic [4:0] rs,
                                  input int ls, output int sel, output bit lu);
      sel = 0;
      lu  = 0;
      if (u && rs != 0) begin
         for (int i = 0; i < p.size(); i++) begin
            if (p[i].v && p[i].w && p[i].rd == rs) begin
               if (p[i].ld && (i + 1) < ls) lu = 1;
               else sel = i + 1;
               break;
            end
         end
      end
   endfunction

   function automatic void model_eval(input ent_t p[$], input int mc, input int ls,
                                      output exp_t e, output bit iss);
      int sa, sb;
      bit la, lb, busy, stall;
      lookup(p, useRs1, rs1, ls, sa, la);
      lookup(p, useRs2, rs2, ls, sb, lb);
      busy  = (mc != 0);
      stall = idValid && (la || lb || busy);
      e      = '0;
      e.sa   = 3'(sa);
      e.sb   = 3'(sb);
      e.pcs  = stall && !redirect;
      e.ifs  = stall && !redirect;
      e.bub  = stall || redirect;
      e.fl   = redirect;
      e.busy = busy;
      iss    = idValid && !stall && !redirect;
   endfunction

   function automatic void model_step(input ent_t p[$], input int mc, input bit iss,
                                      output ent_t q[$], output int mco);
      ent_t nw;
      nw = '0;
      if (iss) begin
         nw.v  = 1'b1;
         nw.rd = idRd;
         nw.w  = idWreg;
         nw.ld = idIsLoad;
      end
      q = p;
      if (mc == 0) q.push_front(nw);
      else q.insert(1, ent_t'(0));
      void'(q.pop_back());
      if (iss && idIsMc) mco = (idMcLat == 0) ? 0 : int'(idMcLat) - 1;
      else mco = (mc > 0) ? mc - 1 : 0;
   endfunction

   task automatic drive(input bit vld, input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                        input bit w, input bit ld, input bit mc, input logic [5:0] lat,
                        input bit redir);
      ent_t np[$];
      int   nm;
      exp_t e;
      @(posedge clk);
      if (rst_n) begin
         model_step(pipe0, mc0, iss0, np, nm); pipe0 = np; mc0 = nm;
         model_step(pipe1, mc1, iss1, np, nm); pipe1 = np; mc1 = nm;
      end
      #1;
      rst_n = 1'b1; idValid = vld; rs1 = r1; useRs1 = u1; rs2 = r2; useRs2 = u2;
      idRd = rd; idWreg = w; idIsLoad = ld; idIsMc = mc; idMcLat = lat; redirect = redir;
      model_eval(pipe0, mc0, 2, e, iss0); expq0.push_back(e);
      model_eval(pipe1, mc1, 3, e, iss1); expq1.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; idValid = 0; useRs1 = 0; useRs2 = 0; redirect = 0; idIsMc = 0;
      model_clear(pipe0, mc0, 3);
      model_clear(pipe1, mc1, 5);
      iss0 = 0; iss1 = 0;
      expq0.push_back('0);
      expq1.push_back('0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (expq0.size() > 0) begin
         me0 = expq0.pop_front();
         chk("u0_sel", int'({1'b0, qa0, 1'b0, qb0}), int'({me0.sa, me0.sb}));
         chk("u0_ctl", int'({pcs0, ifs0, bub0, fl0, busy0}),
             int'({me0.pcs, me0.ifs, me0.bub, me0.fl, me0.busy}));
      end
      if (expq1.size() > 0) begin
         me1 = expq1.pop_front();
         chk("u1_sel", int'({qa1, qb1}), int'({me1.sa, me1.sb}));
         chk("u1_ctl", int'({pcs1, ifs1, bub1, fl1, busy1}),
             int'({me1.pcs, me1.ifs, me1.bub, me1.fl, me1.busy}));
      end
   end

   initial begin
      rst_n = 1'b0; idValid = 0; rs1 = 0; rs2 = 0; useRs1 = 0; useRs2 = 0; idRd = 0;
      idWreg = 0; idIsLoad = 0; idIsMc = 0; idMcLat = 1; redirect = 0;
      model_clear(pipe0, mc0, 3);
      model_clear(pipe1, mc1, 5);
      iss0 = 0; iss1 = 0;

      do_reset();
      do_reset();
      chk("rst_pcstall", pcs0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_qasel", qa0, 0);

      // x0 destination never forwards
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
      chk("x0_qasel", qa0, 0);
      chk("x0_stall", pcs0, 0);
      repeat (6) idle();

      // load-use: one stall at 3/2, two stalls at 5/3
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0);
      drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 1, 0);
      chk("lu_pcstall", pcs0, 1);
      chk("lu_ifidstall", ifs0, 1);
      chk("lu_bubble", bub0, 1);
      chk("lu5_stall1", pcs1, 1);
      drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 1, 0);
      chk("lu_qasel", qa0, 2);
      chk("lu_nostall", pcs0, 0);
      chk("lu5_stall2", pcs1, 1);
      drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 1, 0);
      chk("lu5_qasel", qa1, 3);
      chk("lu5_nostall", pcs1, 0);
      repeat (6) idle();

      // youngest writer wins over an older one further down
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0);
      idle();
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0);
      drive(1, 0, 0, 7, 1, 10, 1, 0, 0, 1, 0);
      chk("fwd_qbsel1", qb0, 1);
      chk("fwd_nostall", pcs0, 0);
      drive(1, 0, 0, 7, 1, 10, 1, 0, 0, 1, 0);
      chk("fwd_qbsel2", qb0, 2);
      repeat (6) idle();

      // multicycle latency 4: three busy cycles
      drive(1, 0, 0, 0, 0, 12, 1, 0, 1, 4, 0);
      for (int c = 0; c < 4; c++) begin
         drive(1, 3, 1, 0, 0, 13, 1, 0, 0, 1, 0);
         chk("mc_busy", busy0, int'(c < 3));
         chk("mc_stall", pcs0, int'(c < 3));
      end
      repeat (6) idle();

      // redirect during a load-use stall
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0);
      drive(1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 1);
      chk("rd_flush", fl0, 1);
      chk("rd_pcstall", pcs0, 0);
      chk("rd_bubble", bub0, 1);
      drive(1, 5, 1, 0, 0, 9, 1, 0, 0, 1, 0);
      chk("rd_qasel", qa0, 2);
      chk("rd_nostall", pcs0, 0);
      repeat (6) idle();

      // reset aborts a multicycle op
      drive(1, 0, 0, 0, 0, 12, 1, 0, 1, 5, 0);
      drive(1, 3, 1, 0, 0, 13, 1, 0, 0, 1, 0);
      do_reset();
      drive(1, 3, 1, 0, 0, 13, 1, 0, 0, 1, 0);
      chk("rstmc_busy", busy0, 0);
      chk("rstmc_stall", pcs0, 0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) == 0) do_reset();
         else drive($urandom_range(9) < 8, 5'($urandom_range(3)), $urandom_range(9) < 7,
                    5'($urandom_range(3)), $urandom_range(9) < 7, 5'($urandom_range(3)),
                    $urandom_range(9) < 8, $urandom_range(9) < 3, $urandom_range(19) < 2,
                    6'($urandom_range(5)), $urandom_range(99) < 8);
      end

      @(posedge clk);
      @(negedge clk);
      chk("drain0", expq0.size(), 0);
      chk("drain1", expq1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 3, meaning number of forwarding stages after ID (stage 1 = EXE, ascending); legal range 2..6.
REQ-002 SHALL provide parameter LOAD_STAGE, default 2, meaning the first stage index whose load result is forwardable; legal range 1..NUM_STAGES.
REQ-003 SHALL provide parameter MC_LAT_W, default 6, meaning the width of the multicycle latency field.
REQ-004 SHALL define SEL_W = clog2(NUM_STAGES+1).
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  idValid  in  1  ID stage holds a valid instruction
  rs1, rs2  in  5  ID source registers
  useRs1, useRs2  in  1  the instruction reads that source
  idRd  in  5  ID destination register
  idWreg  in  1  the ID instruction writes the register file
  idIsLoad  in  1  the ID instruction is a load
  idIsMc  in  1  the ID instruction is a multicycle op
  idMcLat  in  MC_LAT_W  multicycle EXE occupancy in cycles, >=1
  redirect  in  1  EXE resolved a taken branch/jump this cycle
  qaSel, qbSel  out  SEL_W  forward select: 0 = register file, k = stage k
  pcStall, ifidStall  out  1  hold PC / IF-ID register
  idexBubble  out  1  write NOP into ID/EXE register
  ifidFlush  out  1  invalidate IF/ID register
  mcBusy  out  1  multicycle op occupying EXE

Function
REQ-006 SHALL keep a tracker of NUM_STAGES entries {v, rd, wreg, isLoad}, entry k = instruction in stage k.
REQ-007 SHALL compute issue = idValid & !stall & !redirect, stall = idValid & (loadUse | mcBusy).
REQ-008 Each clock, when mcBusy=0: entry1 <= issue ? {1, idRd, idWreg, idIsLoad} : invalid; entry k+1 <= entry k.
REQ-009 Each clock, when mcBusy=1: entry1 holds; entry2 <= invalid; entries k>=3 <= entry k-1.
REQ-010 For each source with use=1 and rs!=0: match = lowest k with v & wreg & rd==rs; rd==0 entries never match.
REQ-011 No match -> sel 0; match with isLoad and k<LOAD_STAGE -> loadUse=1, sel 0; otherwise sel = k.
REQ-012 Source with use=0 or rs=0 -> sel 0, never contributes to loadUse.
REQ-013 stall=1 -> pcStall=1, ifidStall=1, idexBubble=1, same cycle (combinational).
REQ-014 redirect=1 -> ifidFlush=1, idexBubble=1, pcStall=0, ifidStall=0, regardless of stall or mcBusy; ID instruction never issues.
REQ-015 SHALL hold counter mcCnt (MC_LAT_W bits); on issue with idIsMc=1, mcCnt <= idMcLat-1; else if mcCnt!=0, mcCnt decrements by 1.
REQ-016 mcBusy = (mcCnt!=0); idMcLat=1 behaves as a single-cycle op; idMcLat=0 SHALL be treated as 1.
REQ-017 redirect SHALL NOT modify mcCnt or entries k>=2.
REQ-018 Outputs SHALL be purely combinational from tracker, mcCnt and current inputs; no output register latency.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all tracker valid bits and mcCnt to 0.
REQ-020 During and after reset with idValid=0: qaSel=qbSel=0, pcStall=ifidStall=idexBubble=ifidFlush=mcBusy=0.
REQ-021 Reset asserted mid-multicycle or mid-stall SHALL abort it; first cycle after release has no stall.

Verification
REQ-022 Load x5 issued, next instr uses rs1=x5 (defaults) -> cycle N+1 pcStall=ifidStall=idexBubble=1, next cycle qaSel=2, no stall.
REQ-023 ADD x7 then consumer rs2=x7 -> qbSel=1, no stall; one cycle later via bubble -> qbSel=2; older x7 in stage 3 ignored when stage 1 matches.
REQ-024 rs1=x0 with stage 1 rd=x0 wreg=1 -> qaSel=0, no stall.
REQ-025 idIsMc, idMcLat=4 issued -> mcBusy=1 for 3 cycles, following valid instr stalls 3 cycles, entry2 bubbles, issues on 4th.
REQ-026 redirect during loadUse stall -> ifidFlush=1, pcStall=0, entry1 invalid next cycle.
REQ-027 NUM_STAGES=5, LOAD_STAGE=3: load followed by consumer -> 2 stall cycles, then sel=3.
